// File: rtl/face_sys_sequencer.sv
// Instruction-driven sequencer for the FACE systolic multiply engine: decodes
// configuration/compute instructions, launches the engine and tracks completion.
module face_sys_sequencer #(
  parameter logic [6:0]       SYSOPCODE      = 7'b0001011,
  parameter int unsigned      CNT_W          = 20,
  parameter logic [CNT_W-1:0] TIMEOUT_CYCLES = 20'd262143
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  input  logic             instr_valid,
  output logic             instr_ready,
  output logic [31:0]      base_addr_left,
  output logic [31:0]      base_addr_right,
  output logic [31:0]      base_addr_addsrc,
  output logic [31:0]      base_addr_save,
  output logic [15:0]      matrix_size,
  output logic [2:0]       mem_mode,
  output logic             calc_init,
  input  logic             calc_done,
  output logic             busy,
  output logic             done,
  output logic             err_illegal,
  output logic             err_timeout,
  output logic [CNT_W-1:0] last_cycles
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_BUSY, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [31:0]       addr_left_q, addr_left_d;
  logic [31:0]       addr_right_q, addr_right_d;
  logic [31:0]       addr_addsrc_q, addr_addsrc_d;
  logic [31:0]       addr_save_q, addr_save_d;
  logic [15:0]       matrix_size_q, matrix_size_d;
  logic [2:0]        mem_mode_q, mem_mode_d;
  logic              err_illegal_q, err_illegal_d;
  logic              err_timeout_q, err_timeout_d;
  logic [CNT_W-1:0]  last_cycles_q, last_cycles_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [6:0]  opcode;
  logic [2:0]  func;
  logic [2:0]  sel;
  logic [18:0] imm;
  logic        accept;

  assign opcode = instr[6:0];
  assign func   = instr[9:7];
  assign sel    = instr[12:10];
  assign imm    = instr[31:13];
  assign accept = instr_valid && (state_q == S_IDLE) && (opcode == SYSOPCODE);

  always_comb begin
    state_d       = state_q;
    addr_left_d   = addr_left_q;
    addr_right_d  = addr_right_q;
    addr_addsrc_d = addr_addsrc_q;
    addr_save_d   = addr_save_q;
    matrix_size_d = matrix_size_q;
    mem_mode_d    = mem_mode_q;
    err_illegal_d = 1'b0;
    err_timeout_d = err_timeout_q;
    last_cycles_d = last_cycles_q;
    cnt_d         = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (func)
            3'd0: begin
              case (sel)
                3'd0:    addr_left_d   = {13'd0, imm};
                3'd1:    addr_right_d  = {13'd0, imm};
                3'd2:    addr_addsrc_d = {13'd0, imm};
                3'd3:    addr_save_d   = {13'd0, imm};
                default: err_illegal_d = 1'b1;
              endcase
            end
            3'd1: begin
              if (imm[15:0] == '0) err_illegal_d = 1'b1;
              else                 matrix_size_d = imm[15:0];
            end
            3'd2: begin
              if (matrix_size_q == '0) begin
                err_illegal_d = 1'b1;
              end else begin
                mem_mode_d = sel;
                state_d    = S_START;
              end
            end
            3'd3:    err_timeout_d = 1'b0;
            default: err_illegal_d = 1'b1;
          endcase
        end
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_BUSY;
      end
      S_BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        // completion wins over timeout when both land in the same cycle
        if (calc_done) begin
          last_cycles_d = cnt_q + CNT_W'(1);
          state_d       = S_DONE;
        end else if (cnt_q == TIMEOUT_CYCLES - CNT_W'(1)) begin
          err_timeout_d = 1'b1;
          last_cycles_d = TIMEOUT_CYCLES;
          state_d       = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      addr_left_q   <= '0;
      addr_right_q  <= '0;
      addr_addsrc_q <= '0;
      addr_save_q   <= '0;
      matrix_size_q <= '0;
      mem_mode_q    <= '0;
      err_illegal_q <= 1'b0;
      err_timeout_q <= 1'b0;
      last_cycles_q <= '0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      addr_left_q   <= addr_left_d;
      addr_right_q  <= addr_right_d;
      addr_addsrc_q <= addr_addsrc_d;
      addr_save_q   <= addr_save_d;
      matrix_size_q <= matrix_size_d;
      mem_mode_q    <= mem_mode_d;
      err_illegal_q <= err_illegal_d;
      err_timeout_q <= err_timeout_d;
      last_cycles_q <= last_cycles_d;
      cnt_q         <= cnt_d;
    end
  end

  assign instr_ready      = (state_q == S_IDLE);
  assign calc_init        = (state_q == S_START);
  assign busy             = (state_q == S_START) || (state_q == S_BUSY);
  assign done             = (state_q == S_DONE);
  assign base_addr_left   = addr_left_q;
  assign base_addr_right  = addr_right_q;
  assign base_addr_addsrc = addr_addsrc_q;
  assign base_addr_save   = addr_save_q;
  assign matrix_size      = matrix_size_q;
  assign mem_mode         = mem_mode_q;
  assign err_illegal      = err_illegal_q;
  assign err_timeout      = err_timeout_q;
  assign last_cycles      = last_cycles_q;

endmodule

// File: tb/tb_face_sys_sequencer.sv
// Scoreboard bench for face_sys_sequencer: a default-timeout instance for the
// main flow and a short-timeout instance for the abort path.
module tb_face_sys_sequencer;

  localparam logic [6:0] OP = 7'b0001011;
  localparam int unsigned EV_INIT = 0;
  localparam int unsigned EV_DONE = 1;
  localparam int unsigned EV_ILL  = 2;

  typedef struct {
    int unsigned src;
    int unsigned kind;
    int unsigned a;
    int unsigned b;
    int unsigned c;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // main instance
  logic [31:0] instr = '0;
  logic        instr_valid = 1'b0;
  logic        calc_done = 1'b0;
  logic        instr_ready, calc_init, busy, done, err_illegal, err_timeout;
  logic [31:0] ba_left, ba_right, ba_addsrc, ba_save;
  logic [15:0] matrix_size;
  logic [2:0]  mem_mode;
  logic [19:0] last_cycles;

  // short-timeout instance
  logic [31:0] t_instr = '0;
  logic        t_valid = 1'b0;
  logic        t_calc_done = 1'b0;
  logic        t_ready, t_calc_init, t_busy, t_done, t_err_illegal, t_err_timeout;
  logic [31:0] t_left, t_right, t_addsrc, t_save;
  logic [15:0] t_matrix_size;
  logic [2:0]  t_mem_mode;
  logic [19:0] t_last_cycles;

  face_sys_sequencer dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .base_addr_left(ba_left), .base_addr_right(ba_right),
    .base_addr_addsrc(ba_addsrc), .base_addr_save(ba_save), .matrix_size(matrix_size),
    .mem_mode(mem_mode), .calc_init(calc_init), .calc_done(calc_done), .busy(busy),
    .done(done), .err_illegal(err_illegal), .err_timeout(err_timeout),
    .last_cycles(last_cycles)
  );

  face_sys_sequencer #(.TIMEOUT_CYCLES(20'd8)) dut_to (
    .clk(clk), .rst(rst), .instr(t_instr), .instr_valid(t_valid),
    .instr_ready(t_ready), .base_addr_left(t_left), .base_addr_right(t_right),
    .base_addr_addsrc(t_addsrc), .base_addr_save(t_save), .matrix_size(t_matrix_size),
    .mem_mode(t_mem_mode), .calc_init(t_calc_init), .calc_done(t_calc_done), .busy(t_busy),
    .done(t_done), .err_illegal(t_err_illegal), .err_timeout(t_err_timeout),
    .last_cycles(t_last_cycles)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;
  ev_t         sbq[$];
  int unsigned run[2];
  int unsigned acc_cnt = 0;
  logic        hs_s = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int unsigned src, input int unsigned kind,
                      input int unsigned a, input int unsigned b, input int unsigned c);
    ev_t e;
    e.src = src; e.kind = kind; e.a = a; e.b = b; e.c = c;
    sbq.push_back(e);
  endtask

  task automatic pop(input int unsigned src, input int unsigned kind, output ev_t e, output bit ok);
    ok = 1'b0;
    e  = '{default: 0};
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event src=%0d kind=%0d expected=none @%0t", src, kind, $time);
    end else begin
      e = sbq.pop_front();
      chk("event_src", src, e.src);
      chk("event_kind", kind, e.kind);
      ok = (src == e.src) && (kind == e.kind);
    end
  endtask

  task automatic observe(input int unsigned src, input logic ci, input logic dn,
                         input logic ei, input logic by, input logic rdy,
                         input logic [15:0] ms, input logic [2:0] mm,
                         input logic [19:0] lc, input logic et);
    ev_t e;
    bit  ok;
    if (by) begin
      run[src]++;
      chk("ready_low_while_busy", rdy, 0);
    end
    if (ci) begin
      pop(src, EV_INIT, e, ok);
      if (ok) begin
        chk("init_matrix_size", ms, e.a);
        chk("init_mem_mode", mm, e.b);
      end
    end
    if (dn) begin
      pop(src, EV_DONE, e, ok);
      if (ok) begin
        chk("done_last_cycles", lc, e.a);
        chk("done_err_timeout", et, e.b);
        chk("busy_cycles", run[src], e.c);
      end
      run[src] = 0;
    end
    if (ei) pop(src, EV_ILL, e, ok);
  endtask

  // Monitor: samples settled outputs shortly after each falling edge
  initial begin
    run[0] = 0;
    run[1] = 0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        run[0] = 0;
        run[1] = 0;
      end else begin
        observe(0, calc_init, done, err_illegal, busy, instr_ready,
                matrix_size, mem_mode, last_cycles, err_timeout);
        observe(1, t_calc_init, t_done, t_err_illegal, t_busy, t_ready,
                t_matrix_size, t_mem_mode, t_last_cycles, t_err_timeout);
      end
    end
  end

  // Handshake counter for the main instance
  initial forever begin
    @(negedge clk);
    #2;
    hs_s = instr_valid && instr_ready && !rst;
  end
  always @(posedge clk) if (hs_s) acc_cnt++;

  function automatic logic [31:0] mk(input logic [2:0] func, input logic [2:0] sel,
                                     input logic [18:0] imm, input logic [6:0] op);
    return {imm, sel, func, op};
  endfunction

  task automatic send(input int unsigned src, input logic [31:0] w);
    int unsigned n;
    logic        rdy;
    @(negedge clk);
    if (src == 0) begin instr = w; instr_valid = 1'b1; end
    else          begin t_instr = w; t_valid = 1'b1; end
    n = 0;
    forever begin
      rdy = (src == 0) ? instr_ready : t_ready;
      if (rdy || n >= 200) break;
      @(negedge clk);
      n++;
    end
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL send_accept src=%0d ready never rose within %0d cycles", src, n);
    end else begin
      @(posedge clk);
    end
    @(negedge clk);
    if (src == 0) instr_valid = 1'b0;
    else          t_valid = 1'b0;
  endtask

  task automatic check_reset();
    chk("rst_left", ba_left, 0);
    chk("rst_right", ba_right, 0);
    chk("rst_addsrc", ba_addsrc, 0);
    chk("rst_save", ba_save, 0);
    chk("rst_matrix", matrix_size, 0);
    chk("rst_mem_mode", mem_mode, 0);
    chk("rst_calc_init", calc_init, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err_illegal", err_illegal, 0);
    chk("rst_err_timeout", err_timeout, 0);
    chk("rst_last_cycles", last_cycles, 0);
    chk("rst_ready", instr_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned acc0;
    int unsigned n;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_reset();

    // Illegal instructions with all registers still zero
    push(0, EV_ILL, 0, 0, 0); send(0, mk(3'd0, 3'd5, 19'h11111, OP));
    push(0, EV_ILL, 0, 0, 0); send(0, mk(3'd6, 3'd0, 19'h0, OP));
    push(0, EV_ILL, 0, 0, 0); send(0, mk(3'd2, 3'd1, 19'h0, OP));
    push(0, EV_ILL, 0, 0, 0); send(0, mk(3'd1, 3'd0, 19'h0, OP));
    chk("ill_left", ba_left, 0);
    chk("ill_right", ba_right, 0);
    chk("ill_save", ba_save, 0);
    chk("ill_matrix", matrix_size, 0);

    // Configuration then compute with 10-cycle engine latency
    send(0, mk(3'd0, 3'd0, 19'h12345, OP));
    send(0, mk(3'd0, 3'd3, 19'h7FFFF, OP));
    send(0, mk(3'd1, 3'd0, 19'd64, OP));
    chk("cfg_left", ba_left, 32'h0001_2345);
    chk("cfg_save", ba_save, 32'h0007_FFFF);
    chk("cfg_matrix", matrix_size, 64);
    push(0, EV_ILL, 0, 0, 0); send(0, mk(3'd1, 3'd0, 19'h10000, OP));
    chk("size_zero_keeps", matrix_size, 64);

    push(0, EV_INIT, 64, 2, 0);
    push(0, EV_DONE, 10, 0, 11);
    send(0, mk(3'd2, 3'd2, 19'h0, OP));
    repeat (10) @(negedge clk);
    calc_done = 1'b1;
    @(negedge clk);
    calc_done = 1'b0;
    @(negedge clk);
    chk("post_done_ready", instr_ready, 1);
    chk("post_done_mem_mode", mem_mode, 2);
    chk("post_done_last", last_cycles, 10);

    // Timeout on the short-timeout instance
    send(1, mk(3'd1, 3'd0, 19'd4, OP));
    push(1, EV_INIT, 4, 1, 0);
    push(1, EV_DONE, 8, 1, 9);
    send(1, mk(3'd2, 3'd1, 19'h0, OP));
    n = 0;
    while (!t_ready && n < 50) begin @(negedge clk); n++; end
    chk("to_back_to_idle", t_ready, 1);
    repeat (2) @(negedge clk);
    chk("to_err_sticky", t_err_timeout, 1);
    chk("to_last_cycles", t_last_cycles, 8);
    send(1, mk(3'd3, 3'd0, 19'h0, OP));
    chk("clrerr", t_err_timeout, 0);

    // Backpressure: ADDRSET held during a computation
    push(0, EV_INIT, 64, 5, 0);
    push(0, EV_DONE, 3, 0, 4);
    send(0, mk(3'd2, 3'd5, 19'h0, OP));
    acc0 = acc_cnt;
    fork
      send(0, mk(3'd0, 3'd1, 19'h0ABCD, OP));
      begin
        repeat (3) @(negedge clk);
        chk("bp_right_held", ba_right, 0);
        calc_done = 1'b1;
        @(negedge clk);
        calc_done = 1'b0;
      end
    join
    repeat (3) @(negedge clk);
    chk("bp_right_applied", ba_right, 32'h0000_ABCD);
    chk("bp_accept_count", acc_cnt - acc0, 1);

    // Foreign opcode words look like ADDRSET and CALC but must do nothing
    send(0, mk(3'd0, 3'd0, 19'h55555, 7'h33));
    send(0, mk(3'd2, 3'd3, 19'h0, 7'h33));
    repeat (2) @(negedge clk);
    chk("foreign_left", ba_left, 32'h0001_2345);
    chk("foreign_mem_mode", mem_mode, 5);
    chk("foreign_ready", instr_ready, 1);

    // Reset during BUSY, then a stale completion
    push(0, EV_INIT, 64, 4, 0);
    send(0, mk(3'd2, 3'd4, 19'h0, OP));
    repeat (2) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset();
    calc_done = 1'b1;
    @(negedge clk);
    calc_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("late_done_last", last_cycles, 0);
    chk("late_done_ready", instr_ready, 1);

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/face_sys_sequencer.md
Name: face_sys_sequencer

Overview:
Instruction-driven controller for the systolic multiply engine inside the FACE top level. It accepts 32-bit instructions over a valid/ready handshake and decodes systolic-opcode instructions. Configuration instructions load the engine's base-address and matrix-size registers. A compute instruction fires a one-cycle calc_init, then tracks the engine until calc_done or a timeout. The block holds off new instructions while a computation is in flight and reports completion, errors and the measured cycle count.

Parameters:
SYSOPCODE, 7'b0001011, opcode value claimed by this block
CNT_W, 20, width of busy/timeout counter
TIMEOUT_CYCLES, 20'd262143, busy cycles before abort

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
instr  input  32  instruction word
instr_valid  input  1  instr is valid this cycle
instr_ready  output  1  block can accept instr this cycle
base_addr_left  output  32  left-operand base address to engine
base_addr_right  output  32  right-operand base address
base_addr_addsrc  output  32  addend base address
base_addr_save  output  32  result save base address
matrix_size  output  16  matrix dimension to engine
mem_mode  output  3  memory mode to engine
calc_init  output  1  one-cycle start pulse to engine
calc_done  input  1  engine completion pulse
busy  output  1  computation in flight
done  output  1  one-cycle completion pulse
err_illegal  output  1  one-cycle pulse: rejected instruction
err_timeout  output  1  sticky timeout flag
last_cycles  output  CNT_W  busy cycles of last computation

Behaviour:
- One clock domain; all state updates on posedge clk. Reset is synchronous, active-high (rst sampled on the clock edge).
- Reset values:
  - all base_addr_* = 0, matrix_size = 0, mem_mode = 0
  - calc_init = 0, busy = 0, done = 0, err_illegal = 0, err_timeout = 0, last_cycles = 0
  - state = IDLE, instr_ready = 1
- Instruction fields:
  - opcode = instr[6:0]
  - func = instr[9:7]
  - sel = instr[12:10]
  - imm = instr[31:13] (19 bits)
- Handshake:
  - An instruction is accepted when instr_valid && instr_ready.
  - instr_ready = 1 only in IDLE; it is combinational from state.
- Accepted instructions with opcode != SYSOPCODE are ignored silently: no state change, no error.
- func 0, ADDRSET; registers update the cycle after acceptance:
  - sel 0: base_addr_left <= {13'd0, imm}
  - sel 1: base_addr_right <= {13'd0, imm}
  - sel 2: base_addr_addsrc <= {13'd0, imm}
  - sel 3: base_addr_save <= {13'd0, imm}
  - sel 4..7: err_illegal pulse, no register change
- func 1, SIZESET: matrix_size <= imm[15:0]. imm[15:0] == 0 is illegal: err_illegal pulse, matrix_size keeps its old value.
- func 2, CALC:
  - If matrix_size == 0: err_illegal pulse, stay in IDLE.
  - Otherwise: mem_mode <= sel, next state START.
- func 3, CLRERR: err_timeout <= 0.
- func 4..7: err_illegal pulse.
- Config registers are stable and change only in IDLE.
- State machine:
  - IDLE: waits for an accepted CALC.
  - START: calc_init = 1 for exactly this cycle; busy = 1; counter <= 0. Next state BUSY.
  - BUSY: busy = 1; counter increments each cycle.
    - If calc_done: last_cycles <= counter + 1, next state DONE.
    - Else if counter == TIMEOUT_CYCLES - 1: err_timeout <= 1, last_cycles <= TIMEOUT_CYCLES, next state DONE.
    - calc_done takes priority over timeout when both occur in the same cycle.
  - DONE: done = 1 for exactly this cycle (also on timeout); busy = 0. Next state IDLE.
- Latency:
  - CALC accepted at cycle t -> calc_init at t+1.
  - calc_done at cycle u -> done at u+1 -> instr_ready at u+2.
- calc_done arriving in IDLE, START or DONE is ignored.
- err_timeout is cleared only by rst or CLRERR. It does not block new CALCs.
- rst asserted mid-computation returns to IDLE with all reset values on the next edge. The engine is not otherwise notified.

Test Plan:
- ADDRSET then CALC:
  - Stimulus: ADDRSET sel0 imm=0x12345, sel3 imm=0x7FFFF; SIZESET imm=64; CALC sel=2.
  - Expected: base_addr_left=0x00012345 and base_addr_save=0x0007FFFF; matrix_size=64; mem_mode=2; calc_init high for exactly 1 cycle, the cycle after acceptance.
- Normal completion:
  - Stimulus: CALC, then calc_done pulsed 10 cycles after calc_init.
  - Expected: busy high for 11 cycles (START plus 10 BUSY cycles); done high 1 cycle after calc_done; last_cycles=10; instr_ready=0 throughout.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES overridden to 8; CALC issued with no calc_done.
  - Expected: err_timeout=1, last_cycles=8, done pulse, return to IDLE; a following CLRERR gives err_timeout=0.
- Illegal instructions:
  - Stimulus: ADDRSET sel=5; func=6; CALC with matrix_size=0; SIZESET imm=0.
  - Expected: each gives one err_illegal pulse; registers unchanged; no calc_init.
- Backpressure and foreign opcodes:
  - Stimulus: instr_valid held high with ADDRSET during BUSY; opcode 7'h33 in IDLE.
  - Expected: ADDRSET is not accepted until IDLE, then applied exactly once; the foreign opcode causes no change and no error.
- Reset mid-op:
  - Stimulus: rst asserted for 1 cycle in BUSY.
  - Expected: all outputs return to reset values and instr_ready=1 the next cycle; a late calc_done is ignored.
